mib_output_buffer: RTL
======================

Name: mib_output_buffer

Overview:
- One output buffer of a functional unit. It sits directly downstream of the 8-way move-instruction demux, which drives one instance per buffer index 0..7.
- It queues result values produced by the unit.
- It accepts one move instruction at a time from the demux. Each instruction names a destination address.
- It pairs the oldest queued value with the pending instruction and presents the (destination, data) pair to the interconnect under a valid/ready handshake.

Parameters:
- DATA_W, 32, width of result values.
- ADDR_W, 8, width of move_to (destination address); must match the demux interface.
- DEPTH, 4, data FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- move_instr  instruction_output_interface.producer-side consumer port  -  carries move_to[ADDR_W] and move_valid in, move_ack out; connects to one output_buffer_N of the demux
- data_in  in  DATA_W  result value from the unit
- data_valid  in  1  data_in valid
- data_ack  out  1  data_in accepted this cycle
- out_data  out  DATA_W  value sent to the interconnect
- out_dest  out  ADDR_W  destination address
- out_valid  out  1  out_data/out_dest valid
- out_ready  in  1  interconnect accepts
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, instruction slot empty, output register empty, FSM in IDLE; fifo_count=0, out_valid=0, out_data=0, out_dest=0.
  - Reset mid-operation discards all queued data, any pending instruction and any un-accepted output.
- Data side:
  - data_ack = data_valid & ~full. Write on data_ack.
  - No write-through when full: a write is refused even if a pop happens in the same cycle.
  - A written entry is poppable from the next cycle.
- Move side:
  - move_ack = move_valid & ~slot_full, where slot_full is a registered flag. move_ack never depends combinationally on out_ready or data_valid, so the demux ack-OR stays loop-free.
  - On move_ack, move_to is latched into the slot.
  - A move_valid with move_to of any value is legal.
- FSM:
  - IDLE: slot empty. On move_ack go to WAIT_DATA.
  - WAIT_DATA: slot full. When FIFO non-empty and (~out_valid | out_ready), pop the head, load out_data/out_dest, set out_valid, clear the slot, go to SEND.
  - SEND: out_valid held, with data and destination stable, until out_ready.
    - While in SEND, a new move may be accepted, since the slot is free again.
    - On out_ready with the slot full and FIFO non-empty, reload in the same cycle and stay in SEND (back-to-back, one transfer per cycle sustained is not required; one per 2 cycles minimum).
    - On out_ready with no reload: go to IDLE if the slot is empty, or WAIT_DATA if the slot is full.
- Latency:
  - Move accepted at cycle t with FIFO non-empty → out_valid at t+2 (slot latch at t, pop at t+1, register visible t+2).
  - Data written at t into an empty FIFO with the slot already full → out_valid at t+2.
- Simultaneous pop and write:
  - count unchanged; pointers wrap modulo DEPTH.
- Ordering: data leaves strictly FIFO; instructions are served in acceptance order.

Optional Feature:
- Macro: MIB_OUTPUT_BUFFER_KEEP_EN.
- With the macro defined:
  - The move interface carries an extra move_keep bit, latched with move_to.
  - If move_keep=1, the head value is copied to the output register but not popped. This lets one value be sent to several destinations.
  - move_keep=0 behaves as the base block.
- Without the macro: there is no move_keep bit, and every serviced move pops.

Decomposition:
- Package mib_pkg:
  - DATA_W/ADDR_W defaults.
  - typedef of the FSM state enum (IDLE, WAIT_DATA, SEND).
  - typedef of the packed output beat {dest, data}.
- Sub-module mib_sync_fifo: parameterised DATA_W/DEPTH, with wr_en/rd_en, full/empty/count. The buffer instantiates it.

Test Plan:
- Reset, then write 0xA5 with data_valid; move_valid with move_to=0x12, out_ready=1 → data_ack=1, move_ack=1, out_valid exactly 2 cycles after the move, out_data=0xA5, out_dest=0x12; fifo_count returns to 0.
- Move move_to=0x03 with the FIFO empty; 5 cycles later write 0x77 → move_ack immediate; out_valid 2 cycles after the write with out_dest=0x03.
- Fill with 4 writes (DEPTH=4), attempt a 5th → data_ack=0 on the 5th, fifo_count=4; then issue one move and the 5th is accepted only after the pop cycle.
- out_ready=0 for 6 cycles during SEND → out_data/out_dest stable; a second move_valid is acked while out_valid is held; a third move_valid is not acked until the slot clears.
- Assert rst_n low while in SEND with 3 entries queued → out_valid=0 immediately, fifo_count=0, move_ack=0 until a new move_valid after release.
- With MIB_OUTPUT_BUFFER_KEEP_EN: write 0x5A; move (0x01, keep=1), then move (0x02, keep=0) → two beats carry 0x5A to 0x01 then 0x02; fifo_count goes 1,1,0.

Source files
------------

// File: rtl/mib_pkg.sv
// Shared defaults and types for the move-instruction output buffer.
package mib_pkg;

  localparam int MIB_DATA_W = 32;
  localparam int MIB_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    SEND
  } mib_state_e;

  typedef struct packed {
    logic [MIB_ADDR_W-1:0] dest;
    logic [MIB_DATA_W-1:0] data;
  } mib_beat_t;

endpackage

// File: rtl/instruction_output_interface.sv
// Move-instruction link between the demux (master) and one output buffer (slave).
// MIB_OUTPUT_BUFFER_KEEP_EN adds the move_keep bit.
interface instruction_output_interface #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] move_to;
  logic              move_valid;
  logic              move_ack;
`ifdef MIB_OUTPUT_BUFFER_KEEP_EN
  logic              move_keep;

  modport master (output move_to, output move_valid, output move_keep, input move_ack);
  modport slave  (input move_to, input move_valid, input move_keep, output move_ack);
`else
  modport master (output move_to, output move_valid, input move_ack);
  modport slave  (input move_to, input move_valid, output move_ack);
`endif
endinterface

// File: rtl/mib_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module mib_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/mib_output_buffer.sv
// Pairs queued unit results with move instructions and sends {dest,data} beats.
// MIB_OUTPUT_BUFFER_KEEP_EN enables move_keep (send head without popping).
module mib_output_buffer
  import mib_pkg::*;
#(
  parameter int DATA_W = MIB_DATA_W,
  parameter int ADDR_W = MIB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instruction_output_interface.slave move_instr,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   data_valid,
  output logic                   data_ack,
  output logic [DATA_W-1:0]      out_data,
  output logic [ADDR_W-1:0]      out_dest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count
);
  mib_state_e        state_q, state_d;
  logic              slot_full_q, slot_full_d;
  logic [ADDR_W-1:0] slot_dest_q, slot_dest_d;
  logic              slot_keep_q, slot_keep_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_dest_q, out_dest_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              move_ack, load, pop;

  // move_ack looks only at a registered flag so the demux ack-OR stays loop-free.
  assign move_ack            = move_instr.move_valid & ~slot_full_q;
  assign move_instr.move_ack = move_ack;
  assign data_ack            = data_valid & ~fifo_full;
  assign load                = slot_full_q & ~fifo_empty & ((state_q != SEND) | out_ready);
  assign pop                 = load & ~slot_keep_q;

  mib_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_ack),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_dest_d = slot_dest_q;
    slot_keep_d = slot_keep_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    if (load) begin
      slot_full_d = 1'b0;
      out_data_d  = fifo_head;
      out_dest_d  = slot_dest_q;
    end else if (move_ack) begin
      slot_full_d = 1'b1;
      slot_dest_d = move_instr.move_to;
`ifdef MIB_OUTPUT_BUFFER_KEEP_EN
      slot_keep_d = move_instr.move_keep;
`else
      slot_keep_d = 1'b0;
`endif
    end
    case (state_q)
      IDLE:      if (move_ack) state_d = WAIT_DATA;
      WAIT_DATA: if (load)     state_d = SEND;
      SEND: begin
        if (out_ready) begin
          if (load)             state_d = SEND;
          else if (slot_full_d) state_d = WAIT_DATA;
          else                  state_d = IDLE;
        end
      end
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_full_q <= 1'b0;
      slot_dest_q <= '0;
      slot_keep_q <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot_dest_q <= slot_dest_d;
      slot_keep_q <= slot_keep_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_dest  = out_dest_q;

endmodule
